// File: rtl/snitch_pkg.sv
// Shared Snitch types: the reqrsp AMO opcode and the default TCDM bank request/response structs.
package snitch_pkg;

  localparam int unsigned TcdmAddrWidth = 32;
  localparam int unsigned TcdmDataWidth = 64;
  localparam int unsigned TcdmUserWidth = 5;

  typedef enum logic [3:0] {
    AMONone = 4'd0,
    AMOSwap = 4'd1,
    AMOAdd  = 4'd2,
    AMOAnd  = 4'd3,
    AMOOr   = 4'd4,
    AMOXor  = 4'd5,
    AMOMax  = 4'd6,
    AMOMaxu = 4'd7,
    AMOMin  = 4'd8,
    AMOMinu = 4'd9,
    AMOLR   = 4'd10,
    AMOSC   = 4'd11
  } amo_op_e;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0]   addr;
    logic                       write;
    amo_op_e                    amo;
    logic [TcdmDataWidth-1:0]   data;
    logic [TcdmDataWidth/8-1:0] strb;
    logic [TcdmUserWidth-1:0]   user;
  } tcdm_mem_req_chan_t;

  typedef struct packed {
    logic               q_valid;
    tcdm_mem_req_chan_t q;
  } tcdm_mem_req_t;

  typedef struct packed {
    logic [TcdmDataWidth-1:0] data;
  } tcdm_mem_rsp_chan_t;

  typedef struct packed {
    logic               q_ready;
    tcdm_mem_rsp_chan_t p;
  } tcdm_mem_rsp_t;

  // Encodings outside the defined opcode range degrade to a plain access.
  function automatic amo_op_e amo_legalize(input logic [3:0] raw);
    if (raw <= 4'd11) return amo_op_e'(raw);
    return AMONone;
  endfunction

endpackage

// File: rtl/snitch_amo_alu.sv
// One 32-bit lane of the AMO read-modify-write datapath: a is the memory value, b the operand.
module snitch_amo_alu
  import snitch_pkg::*;
(
  input  amo_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = a_i;
    case (op_i)
      AMOSwap: result_o = b_i;
      AMOAdd:  result_o = a_i + b_i;
      AMOAnd:  result_o = a_i & b_i;
      AMOOr:   result_o = a_i | b_i;
      AMOXor:  result_o = a_i ^ b_i;
      AMOMax:  result_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
      AMOMaxu: result_o = (a_i > b_i) ? a_i : b_i;
      AMOMin:  result_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
      AMOMinu: result_o = (a_i < b_i) ? a_i : b_i;
      default: result_o = a_i;
    endcase
  end

endmodule

// File: rtl/snitch_tcdm_bank_amo.sv
// TCDM bank front-end: 1-cycle SRAM access, local AMO read-modify-write and a single LR/SC reservation.
module snitch_tcdm_bank_amo
  import snitch_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned CoreIdWidth = 5,
  parameter type user_t    = logic [CoreIdWidth-1:0],
  parameter type mem_req_t = tcdm_mem_req_t,
  parameter type mem_rsp_t = tcdm_mem_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  mem_req_t               mem_req_i,
  output mem_rsp_t               mem_rsp_o,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
);

  localparam int unsigned NumLanes = DataWidth / 32;

  typedef enum logic {Idle, AmoWrite} state_e;
  typedef enum logic [1:0] {RspZero, RspSram, RspSc} rsp_sel_e;
  typedef struct packed {
    logic                   valid;
    logic [AddrWidth-1:0]   addr;
    logic [CoreIdWidth-1:0] id;
  } reservation_t;

  state_e                 state_q, state_d;
  rsp_sel_e               rsp_sel_q, rsp_sel_d;
  logic                   sc_fail_q, sc_fail_d;
  amo_op_e                op_q, op_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   operand_q, operand_d;
  logic [DataWidth/8-1:0] strb_q, strb_d;
  reservation_t           res_q, res_d;

  user_t                  user;
  amo_op_e                op;
  logic                   q_ready, accept, sc_match, req, we;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   wdata, alu_res;
  logic [DataWidth/8-1:0] be;
  mem_rsp_t               rsp;

  assign user     = mem_req_i.q.user;
  assign op       = amo_legalize(mem_req_i.q.amo);
  assign q_ready  = (state_q == Idle);
  assign accept   = mem_req_i.q_valid & q_ready;
  assign sc_match = res_q.valid & (res_q.addr == mem_req_i.q.addr)
                  & (res_q.id == user[CoreIdWidth-1:0]);

  for (genvar i = 0; i < NumLanes; i++) begin : gen_lane
    snitch_amo_alu i_alu (
      .op_i     (op_q),
      .a_i      (sram_rdata_i[32*i +: 32]),
      .b_i      (operand_q[32*i +: 32]),
      .result_o (alu_res[32*i +: 32])
    );
  end

  always_comb begin
    req       = 1'b0;
    we        = 1'b0;
    addr      = mem_req_i.q.addr;
    wdata     = mem_req_i.q.data;
    be        = mem_req_i.q.strb;
    state_d   = state_q;
    rsp_sel_d = RspZero;
    sc_fail_d = 1'b0;
    op_d      = op_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    strb_d    = strb_q;
    res_d     = res_q;
    if (state_q == AmoWrite) begin
      req     = 1'b1;
      we      = 1'b1;
      addr    = addr_q;
      wdata   = alu_res;
      be      = strb_q;
      state_d = Idle;
    end else if (accept) begin
      rsp_sel_d = RspSram;
      case (op)
        AMONone: begin
          req = 1'b1;
          we  = mem_req_i.q.write;
        end
        AMOLR: begin
          req   = 1'b1;
          res_d = '{valid: 1'b1, addr: mem_req_i.q.addr, id: user[CoreIdWidth-1:0]};
        end
        AMOSC: begin
          rsp_sel_d   = RspSc;
          sc_fail_d   = ~sc_match;
          req         = sc_match;
          we          = sc_match;
          res_d.valid = 1'b0;
        end
        default: begin
          req       = 1'b1;
          op_d      = op;
          addr_d    = mem_req_i.q.addr;
          operand_d = mem_req_i.q.data;
          strb_d    = mem_req_i.q.strb;
          state_d   = AmoWrite;
        end
      endcase
    end
    // Any store to the reserved word breaks the reservation, whoever issued it.
    if (req && we && (addr == res_q.addr)) res_d.valid = 1'b0;
  end

  always_comb begin
    rsp         = '0;
    rsp.q_ready = q_ready;
    case (rsp_sel_q)
      RspSram: rsp.p.data = sram_rdata_i;
      RspSc:   rsp.p.data = {{(DataWidth-1){1'b0}}, sc_fail_q};
      default: rsp.p.data = '0;
    endcase
  end

  assign mem_rsp_o    = rsp;
  assign sram_req_o   = req & rst_ni;
  assign sram_we_o    = we;
  assign sram_addr_o  = addr;
  assign sram_wdata_o = wdata;
  assign sram_be_o    = be;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      rsp_sel_q <= RspZero;
      sc_fail_q <= 1'b0;
      op_q      <= AMONone;
      addr_q    <= '0;
      operand_q <= '0;
      strb_q    <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      rsp_sel_q <= rsp_sel_d;
      sc_fail_q <= sc_fail_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      strb_q    <= strb_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_snitch_tcdm_bank_amo.sv
// Directed bench for snitch_tcdm_bank_amo with a behavioural 1-cycle SRAM behind it.
module tb_snitch_tcdm_bank_amo;
  import snitch_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  tcdm_mem_req_t req;
  tcdm_mem_rsp_t rsp;
  logic          sram_req, sram_we;
  logic [31:0]   sram_addr;
  logic [63:0]   sram_wdata, sram_rdata;
  logic [7:0]    sram_be;
  logic [63:0]   mem_q [256];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  snitch_tcdm_bank_amo dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_req_i    (req),
    .mem_rsp_o    (rsp),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_be[b]) mem_q[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem_q[sram_addr[7:0]];
      end
    end
  end

  // Drives one request, lets it be accepted on the next edge, samples point is #1 after that edge.
  task automatic issue(input logic [31:0] a, input logic w, input amo_op_e op,
                       input logic [63:0] d, input logic [7:0] s, input logic [4:0] u);
    req.q_valid = 1'b1;
    req.q.addr  = a;
    req.q.write = w;
    req.q.amo   = op;
    req.q.data  = d;
    req.q.strb  = s;
    req.q.user  = u;
    @(posedge clk);
    #1;
    req.q_valid = 1'b0;
  endtask

  task automatic test_reset();
    req.q_valid = 1'b1;
    #1;
    n_cmp++; if (sram_req !== 1'b0) begin n_err++; $display("FAIL reset_sram_req: got %b want 0", sram_req); end
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_err++; $display("FAIL reset_q_ready: got %b want 1", rsp.q_ready); end
    n_cmp++; if (rsp.p.data !== 64'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp.p.data); end
    req.q_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rsp.p.data !== 64'h0) begin n_err++; $display("FAIL post_reset_rsp_data: got %h want 0", rsp.p.data); end
  endtask

  task automatic test_plain_rw();
    issue(32'h10, 1'b1, AMONone, 64'hDEADBEEF_01234567, 8'hFF, 5'd0);
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_err++; $display("FAIL wr_q_ready: got %b want 1", rsp.q_ready); end
    issue(32'h10, 1'b0, AMONone, 64'h0, 8'hFF, 5'd0);
    n_cmp++; if (rsp.p.data !== 64'hDEADBEEF_01234567) begin n_err++; $display("FAIL rd_data: got %h want deadbeef01234567", rsp.p.data); end
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_err++; $display("FAIL rd_q_ready: got %b want 1", rsp.q_ready); end
    issue(32'h30, 1'b1, amo_op_e'(4'hF), 64'h0000_CAFE, 8'hFF, 5'd0);
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_err++; $display("FAIL illegal_q_ready: got %b want 1", rsp.q_ready); end
    n_cmp++; if (mem_q[8'h30] !== 64'h0000_CAFE) begin n_err++; $display("FAIL illegal_as_write: got %h want cafe", mem_q[8'h30]); end
  endtask

  task automatic test_amo_add();
    issue(32'h4, 1'b1, AMONone, 64'hAAAAAAAA_7FFFFFFF, 8'hFF, 5'd0);
    issue(32'h4, 1'b0, AMOAdd, 64'h00000005_00000001, 8'h0F, 5'd2);
    n_cmp++; if (rsp.p.data !== 64'hAAAAAAAA_7FFFFFFF) begin n_err++; $display("FAIL add_old: got %h want aaaaaaaa7fffffff", rsp.p.data); end
    n_cmp++; if (rsp.q_ready !== 1'b0) begin n_err++; $display("FAIL add_stall: got %b want 0", rsp.q_ready); end
    @(posedge clk); #1;
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_err++; $display("FAIL add_ready_back: got %b want 1", rsp.q_ready); end
    n_cmp++; if (mem_q[8'h4] !== 64'hAAAAAAAA_80000000) begin n_err++; $display("FAIL add_mem: got %h want aaaaaaaa80000000", mem_q[8'h4]); end
  endtask

  task automatic test_minmax();
    amo_op_e     ops  [6];
    logic [63:0] opnd [6];
    logic [7:0]  strb [6];
    logic [63:0] expv [6];
    ops[0] = AMOMax;  opnd[0] = 64'h00000001_00000001; strb[0] = 8'h0F; expv[0] = 64'h12345678_00000001;
    ops[1] = AMOMaxu; opnd[1] = 64'h00000001_00000001; strb[1] = 8'h0F; expv[1] = 64'h12345678_FFFFFFFF;
    ops[2] = AMOMin;  opnd[2] = 64'h00000001_00000001; strb[2] = 8'h0F; expv[2] = 64'h12345678_FFFFFFFF;
    ops[3] = AMOMinu; opnd[3] = 64'h00000001_00000001; strb[3] = 8'h0F; expv[3] = 64'h12345678_00000001;
    ops[4] = AMOAnd;  opnd[4] = 64'h0000FFFF_0000FFFF; strb[4] = 8'hFF; expv[4] = 64'h00005678_0000FFFF;
    ops[5] = AMOXor;  opnd[5] = 64'hFFFFFFFF_00000000; strb[5] = 8'hF0; expv[5] = 64'hEDCBA987_FFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      issue(32'h8, 1'b1, AMONone, 64'h12345678_FFFFFFFF, 8'hFF, 5'd0);
      issue(32'h8, 1'b0, ops[i], opnd[i], strb[i], 5'd1);
      n_cmp++; if (rsp.p.data !== 64'h12345678_FFFFFFFF) begin n_err++; $display("FAIL minmax_old[%0d]: got %h want 12345678ffffffff", i, rsp.p.data); end
      @(posedge clk); #1;
      n_cmp++; if (mem_q[8'h8] !== expv[i]) begin n_err++; $display("FAIL minmax_mem[%0d]: got %h want %h", i, mem_q[8'h8], expv[i]); end
    end
  endtask

  task automatic test_lr_sc();
    issue(32'h20, 1'b1, AMONone, 64'h99, 8'hFF, 5'd0);
    issue(32'h20, 1'b0, AMOLR, 64'h0, 8'hFF, 5'd3);
    n_cmp++; if (rsp.p.data !== 64'h99) begin n_err++; $display("FAIL lr_data: got %h want 99", rsp.p.data); end
    issue(32'h20, 1'b0, AMOSC, 64'h5, 8'hFF, 5'd3);
    n_cmp++; if (rsp.p.data !== 64'h0) begin n_err++; $display("FAIL sc_pass: got %h want 0", rsp.p.data); end
    n_cmp++; if (mem_q[8'h20] !== 64'h5) begin n_err++; $display("FAIL sc_pass_mem: got %h want 5", mem_q[8'h20]); end
    issue(32'h20, 1'b0, AMOSC, 64'h7, 8'hFF, 5'd3);
    n_cmp++; if (rsp.p.data !== 64'h1) begin n_err++; $display("FAIL sc_repeat: got %h want 1", rsp.p.data); end
    n_cmp++; if (mem_q[8'h20] !== 64'h5) begin n_err++; $display("FAIL sc_repeat_mem: got %h want 5", mem_q[8'h20]); end
    issue(32'h20, 1'b0, AMOLR, 64'h0, 8'hFF, 5'd3);
    issue(32'h20, 1'b0, AMOSC, 64'h9, 8'hFF, 5'd4);
    n_cmp++; if (rsp.p.data !== 64'h1) begin n_err++; $display("FAIL sc_other_core: got %h want 1", rsp.p.data); end
    issue(32'h20, 1'b0, AMOSC, 64'h9, 8'hFF, 5'd3);
    n_cmp++; if (rsp.p.data !== 64'h1) begin n_err++; $display("FAIL sc_after_clear: got %h want 1", rsp.p.data); end
    n_cmp++; if (mem_q[8'h20] !== 64'h5) begin n_err++; $display("FAIL sc_fail_mem: got %h want 5", mem_q[8'h20]); end
    issue(32'h20, 1'b0, AMOLR, 64'h0, 8'hFF, 5'd3);
    issue(32'h28, 1'b0, AMOLR, 64'h0, 8'hFF, 5'd3);
    issue(32'h28, 1'b0, AMOSC, 64'h6, 8'hFF, 5'd3);
    n_cmp++; if (rsp.p.data !== 64'h0) begin n_err++; $display("FAIL sc_replaced: got %h want 0", rsp.p.data); end
    n_cmp++; if (mem_q[8'h28] !== 64'h6) begin n_err++; $display("FAIL sc_replaced_mem: got %h want 6", mem_q[8'h28]); end
  endtask

  task automatic test_reservation_kill();
    issue(32'h20, 1'b0, AMOLR, 64'h0, 8'hFF, 5'd3);
    issue(32'h20, 1'b1, AMONone, 64'h11, 8'hFF, 5'd1);
    req.q_valid = 1'b1;
    req.q.addr  = 32'h20;
    req.q.write = 1'b0;
    req.q.amo   = AMOSC;
    req.q.data  = 64'h22;
    req.q.strb  = 8'hFF;
    req.q.user  = 5'd3;
    #1;
    n_cmp++; if (sram_req !== 1'b0) begin n_err++; $display("FAIL kill_no_sram_req: got %b want 0", sram_req); end
    @(posedge clk); #1;
    req.q_valid = 1'b0;
    n_cmp++; if (rsp.p.data !== 64'h1) begin n_err++; $display("FAIL kill_sc: got %h want 1", rsp.p.data); end
    n_cmp++; if (mem_q[8'h20] !== 64'h11) begin n_err++; $display("FAIL kill_mem: got %h want 11", mem_q[8'h20]); end
  endtask

  task automatic test_reset_mid_amo();
    issue(32'h40, 1'b1, AMONone, 64'h33, 8'hFF, 5'd0);
    issue(32'h48, 1'b1, AMONone, 64'h10, 8'hFF, 5'd0);
    issue(32'h40, 1'b0, AMOLR, 64'h0, 8'hFF, 5'd2);
    issue(32'h48, 1'b0, AMOAdd, 64'h1, 8'hFF, 5'd2);
    n_cmp++; if (sram_req !== 1'b1) begin n_err++; $display("FAIL amowrite_req: got %b want 1", sram_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sram_req !== 1'b0) begin n_err++; $display("FAIL rst_drops_req: got %b want 0", sram_req); end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rsp.q_ready !== 1'b1) begin n_err++; $display("FAIL rst_q_ready: got %b want 1", rsp.q_ready); end
    n_cmp++; if (mem_q[8'h48] !== 64'h10) begin n_err++; $display("FAIL rst_write_dropped: got %h want 10", mem_q[8'h48]); end
    issue(32'h40, 1'b0, AMOSC, 64'h77, 8'hFF, 5'd2);
    n_cmp++; if (rsp.p.data !== 64'h1) begin n_err++; $display("FAIL rst_res_invalid: got %h want 1", rsp.p.data); end
    n_cmp++; if (mem_q[8'h40] !== 64'h33) begin n_err++; $display("FAIL rst_sc_mem: got %h want 33", mem_q[8'h40]); end
  endtask

  initial begin
    req = '0;
    #12;
    test_reset();
    test_plain_rw();
    test_amo_add();
    test_minmax();
    test_lr_sc();
    test_reservation_kill();
    test_reset_mid_amo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
